// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES carry-chained
// slices, one slice per register stage, with valid/ready flow control and bubble collapse.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SW  = WIDTH / STAGES;
   localparam int OPS = (STAGES > 1) ? STAGES - 1 : 1;

   // Handshake: a beat transfers on any edge where valid && ready; valid never waits on
   // ready, and a stage's ready is combinational from everything downstream of it.
   logic [STAGES-1:0] valid;
   logic [STAGES:0]   rdy;
   logic [STAGES:0]   up_valid;
   logic [STAGES-1:0] load;
   logic [STAGES-1:0] leave;

   logic [WIDTH-1:0]  a_r     [OPS];
   logic [WIDTH-1:0]  b_r     [OPS];
   logic [WIDTH-1:0]  sum_r   [STAGES];
   logic [STAGES-1:0] carry_r;
   logic              ovf_r;

   logic [WIDTH-1:0]  src_a   [STAGES];
   logic [WIDTH-1:0]  src_b   [STAGES];
   logic [WIDTH-1:0]  src_s   [STAGES];
   logic [WIDTH-1:0]  nxt_sum [STAGES];
   logic [SW:0]       slice   [STAGES];
   logic [STAGES-1:0] src_c;
   logic [STAGES-1:0] nxt_c;
   logic              nxt_ovf;

   always_comb begin
      up_valid     = {valid, in_valid};
      rdy          = '0;
      rdy[STAGES]  = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = !valid[k] || rdy[k+1];
      end
      load  = up_valid[STAGES-1:0] & rdy[STAGES-1:0];
      leave = valid & rdy[STAGES:1];
   end

   assign in_ready = rdy[0];

   // Stage 0 sources come from the ports (b pre-inverted for subtract); later stages
   // read the operands and partial sum carried forward by the previous stage.
   always_comb begin
      src_a[0] = a;
      src_b[0] = sub ? ~b : b;
      src_c[0] = sub | cin;
      src_s[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         src_a[k] = a_r[k-1];
         src_b[k] = b_r[k-1];
         src_c[k] = carry_r[k-1];
         src_s[k] = sum_r[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         slice[k] = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_b[k][k*SW +: SW]}
                  + {{SW{1'b0}}, src_c[k]};
         nxt_sum[k]             = src_s[k];
         nxt_sum[k][k*SW +: SW] = slice[k][SW-1:0];
         nxt_c[k]               = slice[k][SW];
      end
      nxt_ovf = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
              ^ nxt_sum[STAGES-1][WIDTH-1] ^ nxt_c[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid   <= '0;
         carry_r <= '0;
         ovf_r   <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            sum_r[k] <= '0;
         end
         for (int k = 0; k < OPS; k++) begin
            a_r[k] <= '0;
            b_r[k] <= '0;
         end
      end else begin
         valid <= load | (valid & ~leave);
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               sum_r[k]   <= nxt_sum[k];
               carry_r[k] <= nxt_c[k];
            end
         end
         for (int k = 0; k < STAGES - 1; k++) begin
            if (load[k]) begin
               a_r[k] <= src_a[k];
               b_r[k] <= src_b[k];
            end
         end
         if (load[STAGES-1]) begin
            ovf_r <= nxt_ovf;
         end
      end
   end

   assign out_valid = valid[STAGES-1];
   assign sum       = sum_r[STAGES-1];
   assign cout      = carry_r[STAGES-1];
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed 8-bit/2-stage vector table plus randomized
// streaming, backpressure and reset scenarios on the default 32-bit/4-stage build.
module tb_pipelined_adder;

   localparam int W = 32;
   localparam int S = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- 32/4 instance ----------------
   logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [W-1:0] a, b, sum;

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   // ---------------- 8/2 instance ----------------
   logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;

   pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
      .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad = 0;
   logic [W+1:0] exp_q[$];
   int           acc_cyc_q[$];
   int           cyc = 0;
   int           acc_cnt = 0;
   int           stall_cnt = 0;
   bit           lat_chk = 0;
   bit           stream_on = 0;
   bit           hold_pend = 0;
   logic [W+1:0] hold_val;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operands, {ovf, cout, sum}.
   function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic c, input logic s);
      logic [W:0]   full;
      logic [W-1:0] r;
      logic         co, o;
      if (s) begin
         r  = x - y;
         co = (x >= y);
         o  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end else begin
         full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
         r    = full[W-1:0];
         co   = full[W];
         o    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      return {o, co, r};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (hold_pend) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", {30'd0, ovf, cout, sum}, {30'd0, hold_val});
         end
         hold_pend = out_valid && !out_ready;
         hold_val  = {ovf, cout, sum};
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_output: got %0h want none", sum);
            end else begin
               chk("result", {30'd0, ovf, cout, sum}, {30'd0, exp_q.pop_front()});
               if (lat_chk) chk("latency", 64'(cyc - acc_cyc_q[0]), 64'(S));
               void'(acc_cyc_q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(a, b, cin, sub));
            acc_cyc_q.push_back(cyc);
            acc_cnt++;
         end
         if (stream_on && in_valid && !in_ready) stall_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_cycle(input bit v, input bit r);
      @(posedge clk);
      #1;
      in_valid  = v;
      out_ready = r;
      a   = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? W'(1) : W'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
   endtask

   task automatic drain_and_check(input string name);
      repeat (12) drive_cycle(1'b0, 1'b1);
      @(negedge clk);
      #1;
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic random_phase(input int n);
      for (int i = 0; i < n; i++) begin
         drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   // ---------------- directed 8-bit table ----------------
   typedef struct {
      logic [7:0] va, vb;
      logic       vcin, vsub;
      logic [7:0] es;
      logic       ec, eo;
   } vec_t;

   vec_t tbl[8];

   task automatic run_table();
      tbl[0] = '{8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0};
      tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      tbl[5] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
      tbl[6] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
      tbl[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         in_valid8 = 1'b1;
         a8 = tbl[i].va;
         b8 = tbl[i].vb;
         cin8 = tbl[i].vcin;
         sub8 = tbl[i].vsub;
         chk("t8_in_ready", {63'd0, in_ready8}, 64'd1);
         @(posedge clk);
         #1;
         in_valid8 = 1'b0;
         chk("t8_not_early", {63'd0, out_valid8}, 64'd0);
         @(posedge clk);
         #1;
         chk("t8_out_valid", {63'd0, out_valid8}, 64'd1);
         chk("t8_sum", {56'd0, sum8}, {56'd0, tbl[i].es});
         chk("t8_cout", {63'd0, cout8}, {63'd0, tbl[i].ec});
         chk("t8_ovf", {63'd0, ovf8}, {63'd0, tbl[i].eo});
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      in_valid = 0; out_ready = 1; a = '0; b = '0; cin = 0; sub = 0;
      in_valid8 = 0; out_ready8 = 1; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0;

      #2;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_sum", {32'd0, sum}, 64'd0);
      chk("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
      chk("rst8_out_valid", {63'd0, out_valid8}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_table();

      // back-to-back stream: one accept per cycle, fixed latency
      drain_and_check("pre_stream_empty");
      acc_cnt = 0;
      stall_cnt = 0;
      stream_on = 1;
      lat_chk = 1;
      repeat (1000) drive_cycle(1'b1, 1'b1);
      drive_cycle(1'b0, 1'b1);
      stream_on = 0;
      drain_and_check("stream_drained");
      lat_chk = 0;
      chk("stream_accepts", 64'(acc_cnt), 64'd1000);
      chk("stream_stalls", 64'(stall_cnt), 64'd0);

      // backpressure: pipeline fills to exactly S entries then holds
      acc_cnt = 0;
      repeat (10) drive_cycle(1'b1, 1'b0);
      @(negedge clk);
      #1;
      chk("bp_accepts", 64'(acc_cnt), 64'(S));
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      drain_and_check("bp_drained");

      random_phase(2000);
      drain_and_check("random_drained");

      // reset with results in flight
      repeat (3) drive_cycle(1'b1, 1'b0);
      repeat (3) drive_cycle(1'b0, 1'b0);
      chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      acc_cyc_q.delete();
      hold_pend = 0;
      chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("mid_rst_sum", {32'd0, sum}, 64'd0);
      chk("mid_rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      random_phase(300);
      drain_and_check("post_rst_drained");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor that generalises the single-bit full adder to WIDTH bits split into STAGES carry-chained slices. Each stage registers one slice's sum and carry, so the critical path is one WIDTH/STAGES-bit ripple. A valid/ready handshake at both ends with per-stage bubble collapse lets it sit between streaming datapath blocks under backpressure.

## Interface
- WIDTH, 32, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; slice width SW = WIDTH/STAGES, and STAGES >= 1.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present on a, b, cin, sub.
- in_ready  output  1  stage 0 can accept this cycle.
- a  input  WIDTH  operand A (two's complement or unsigned).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  output  1  result present on sum, cout, ovf.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow, i.e. a >= b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Transfer at input when in_valid && in_ready; at output when out_valid && out_ready.
- Stage k (0..STAGES-1) holds: valid bit, carry, finished sum slices 0..k, unprocessed operand slices k+1..STAGES-1 (b already inverted if sub), and for the last stage the MSB carry-in for ovf.
- Stage 0 on accept: computes slice 0 = a[SW-1:0] + b'[SW-1:0] + c0, where b' = sub ? ~b : b, c0 = sub ? 1 : cin; stores carry out.
- Stage k>0 on load from stage k-1: adds slice k of stored operands with stored carry; passes earlier sum slices unchanged.
- Final stage drives sum, cout, ovf, out_valid directly from registers (no combinational path from inputs to outputs).
- Bubble collapse: stage k loads when it is empty or its content leaves this cycle (moves to k+1, or final stage handshakes). Stage k empties when content leaves and nothing loads.
- in_ready = !valid[0] || stage 0 leaves this cycle (combinational through the ready chain; out_ready may feed in_ready combinationally).
- Data registers load only when the stage loads; otherwise hold (stable output under stall is required).
- Order preserved; no reordering, no drops, no duplication.
- STAGES=1: single register stage, full-width add.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, so out_valid=0, in_ready=1 after reset; sum=0, cout=0, ovf=0; all internal data registers 0.
- Reset mid-operation discards all in-flight results; first accept after rst_n release is on the first rising edge with in_valid=1.
- Latency: result accepted at edge N appears with out_valid=1 after edge N+STAGES-1... i.e. visible in the cycle after edge N+STAGES-1 when unstalled (STAGES register stages).
- Throughput: one result per cycle when out_ready held 1.
- Full: all STAGES valid and out_ready=0 → in_ready=0; sum/cout/ovf/out_valid hold.
- Full with out_ready=1 and in_valid=1 same cycle: simultaneous drain and accept, occupancy unchanged.
- Empty stages ahead of a stall still absorb new data (up to STAGES results buffered).
- out_valid, once asserted, stays 1 with stable outputs until the handshake completes.

## Test plan
- WIDTH=8, STAGES=2: a=0x3C, b=0x05, cin=1, sub=0 → after 2 cycles sum=0x42, cout=0, ovf=0.
- WIDTH=8, STAGES=2: a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1; a=0xFF, b=0x01 → sum=0x00, cout=1, ovf=0 (carry crosses slice boundary).
- WIDTH=8, sub=1: a=0x05, b=0x07 → sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1; cin=1 ignored.
- Defaults 32/4: stream 1000 random operands back-to-back with out_ready=1 → one result per cycle, latency 4, all match reference a+b+cin / a-b.
- Backpressure: hold out_ready=0 for 10 cycles while in_valid=1 → exactly 4 accepts, then in_ready=0, outputs stable; release → results drain in order, none lost or duplicated; random out_ready/in_valid toggling matches scoreboard.
- Assert rst_n=0 with 3 results in flight → out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 immediately; after release, new operands produce correct results with no stale outputs.
